// File: rtl/ysyx_23060203_exu_mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// single-cycle fast path for divide-by-zero and signed overflow.
module ysyx_23060203_exu_mdu #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1,
  parameter int TAG_W    = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_rd,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_val,
  output logic [TAG_W-1:0] out_rd,
  output logic [TAG_W-1:0] busy_rd
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(XLEN / MUL_STEP);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [2:0]          r_funct;
  logic                r_neg, r_rem_neg;
  logic [2*XLEN-1:0]   r_acc, r_mcand;
  logic [XLEN-1:0]     r_opb;
  logic [XLEN-1:0]     r_out_val;
  logic [TAG_W-1:0]    r_out_rd, r_busy_rd;

  logic                w_accept, w_fast, w_last;
  logic                w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_b_zero, w_ovf;
  logic [XLEN-1:0]     w_abs_a, w_abs_b, w_fast_val;
  logic [2*XLEN-1:0]   w_partial, w_mul_acc, w_div_acc, w_calc_acc, w_prod;
  logic [2*XLEN:0]     w_div_sh;
  logic [XLEN:0]       w_div_hi;
  logic [XLEN-1:0]     w_div_diff, w_quo, w_rem, w_result;

  // Operand decode at accept time.
  assign w_a_signed = (in_funct == 3'b001) | (in_funct == 3'b010) |
                      (in_funct == 3'b100) | (in_funct == 3'b110);
  assign w_b_signed = (in_funct == 3'b001) | (in_funct == 3'b100) | (in_funct == 3'b110);
  assign w_a_neg    = w_a_signed & in_a[XLEN-1];
  assign w_b_neg    = w_b_signed & in_b[XLEN-1];
  assign w_abs_a    = w_a_neg ? -in_a : in_a;
  assign w_abs_b    = w_b_neg ? -in_b : in_b;

  assign w_b_zero   = (in_b == '0);
  assign w_ovf      = (in_funct == 3'b100 || in_funct == 3'b110) &&
                      (in_a == INT_MIN) && (in_b == '1);
  assign w_fast     = in_funct[2] & (w_b_zero | w_ovf);
  assign w_fast_val = w_b_zero ? (in_funct[1] ? in_a : '1)
                               : (in_funct[1] ? '0 : in_a);

  assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
  assign w_accept  = in_valid & in_ready & ~flush;
  assign out_valid = (r_state == S_DONE) & ~flush;
  assign out_val   = r_out_val;
  assign out_rd    = r_out_rd;
  assign busy_rd   = r_busy_rd;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_partial = '0;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (r_opb[j]) w_partial = w_partial + (r_mcand << j);
    end
  end
  assign w_mul_acc = r_acc + w_partial;

  // Restoring step: {remainder, dividend/quotient} shifts left one bit per cycle.
  assign w_div_sh   = {r_acc, 1'b0};
  assign w_div_hi   = w_div_sh[2*XLEN:XLEN];
  assign w_div_diff = w_div_hi[XLEN-1:0] - r_opb;
  assign w_div_acc  = (w_div_hi >= {1'b0, r_opb})
                      ? {w_div_diff, w_div_sh[XLEN-1:1], 1'b1}
                      : w_div_sh[2*XLEN-1:0];

  assign w_calc_acc = r_funct[2] ? w_div_acc : w_mul_acc;
  assign w_cnt_nxt  = r_cnt + CNT_W'(1);
  assign w_last     = (r_state == S_CALC) && (w_cnt_nxt == (r_funct[2] ? DIV_LAST : MUL_LAST));

  assign w_prod = r_neg ? -w_mul_acc : w_mul_acc;
  assign w_quo  = r_neg ? -w_div_acc[XLEN-1:0] : w_div_acc[XLEN-1:0];
  assign w_rem  = r_rem_neg ? -w_div_acc[2*XLEN-1:XLEN] : w_div_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_result = '0;
    unique case (r_funct)
      3'b000:                 w_result = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_result = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_result = w_quo;
      default:                w_result = w_rem;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_fast ? S_DONE : S_CALC;
      S_CALC: if (w_last) w_state_nxt = S_DONE;
      S_DONE: begin
        if (w_accept)       w_state_nxt = w_fast ? S_DONE : S_CALC;
        else if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_out_val <= '0;
      r_out_rd  <= '0;
      r_busy_rd <= '0;
    end else begin
      r_busy_rd <= (w_state_nxt == S_IDLE) ? '0 : (w_accept ? in_rd : r_busy_rd);
      if (w_accept) begin
        r_cnt <= '0;
        if (w_fast) begin
          r_out_val <= w_fast_val;
          r_out_rd  <= in_rd;
        end
      end else if (r_state == S_CALC && !flush) begin
        r_cnt <= w_cnt_nxt;
        if (w_last) begin
          r_out_val <= w_result;
          r_out_rd  <= r_busy_rd;
        end
      end
    end
  end

  // NOTE: the datapath is fully loaded on accept, so it carries no reset.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_funct   <= in_funct;
      r_neg     <= w_a_neg ^ w_b_neg;
      r_rem_neg <= w_a_neg;
      r_acc     <= in_funct[2] ? {{XLEN{1'b0}}, w_abs_a} : '0;
      r_mcand   <= {{XLEN{1'b0}}, w_abs_a};
      r_opb     <= w_abs_b;
    end else if (r_state == S_CALC) begin
      r_acc <= w_calc_acc;
      if (!r_funct[2]) begin
        r_mcand <= r_mcand << MUL_STEP;
        r_opb   <= r_opb >> MUL_STEP;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060203_exu_mdu.sv
// Directed bench for the RV32M multiply/divide unit: results, latency,
// fast path, backpressure, flush and asynchronous reset.
module tb_ysyx_23060203_exu_mdu;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_funct = 3'b000;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [4:0]  in_rd = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_val;
  logic [4:0]  out_rd;
  logic [4:0]  busy_rd;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110;

  ysyx_23060203_exu_mdu #(.XLEN(32), .MUL_STEP(1), .TAG_W(5)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct(in_funct),
    .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
    .out_ready(out_ready), .out_valid(out_valid), .out_val(out_val),
    .out_rd(out_rd), .busy_rd(busy_rd)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one op through a single accept edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    in_valid = 1'b1; in_funct = f; in_a = a; in_b = b; in_rd = rd;
    tick();
    in_valid = 1'b0;
  endtask

  // Cycles from the accept edge until out_valid, bounded.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_val, input int exp_lat);
    int lat;
    check({tag, "/in_ready"}, {31'd0, in_ready}, 32'd1);
    issue(f, a, b, rd);
    check({tag, "/busy_rd"}, {27'd0, busy_rd}, {27'd0, rd});
    wait_valid(lat);
    check({tag, "/latency"}, lat, exp_lat);
    check({tag, "/val"}, out_val, exp_val);
    check({tag, "/rd"}, {27'd0, out_rd}, {27'd0, rd});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "/retired"}, {31'd0, out_valid}, 32'd0);
    check({tag, "/idle_busy"}, {27'd0, busy_rd}, 32'd0);
  endtask

  initial begin
    int lat;
    int seen;

    // Reset
    #2 reset = 1'b0;
    tick(); tick();
    check("rst/out_valid", {31'd0, out_valid}, 32'd0);
    check("rst/out_val", out_val, 32'd0);
    check("rst/out_rd", {27'd0, out_rd}, 32'd0);
    check("rst/busy_rd", {27'd0, busy_rd}, 32'd0);
    check("rst/in_ready", {31'd0, in_ready}, 32'd1);
    #3 reset = 1'b1;
    tick();

    // Multiply family
    run_op("mul",    F_MUL,    32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 33);
    run_op("mulhu",  F_MULHU,  32'd7,        32'hFFFFFFFD, 5'd11, 32'h00000006, 33);
    run_op("mulh",   F_MULH,   32'h80000000, 32'h80000000, 5'd12, 32'h40000000, 33);
    run_op("mulhsu", F_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd13, 32'hFFFFFFFF, 33);

    // Fast path
    run_op("divu0",  F_DIVU,   32'h1234,     32'd0,        5'd14, 32'hFFFFFFFF, 1);
    run_op("rem0",   F_REM,    32'h1234,     32'd0,        5'd15, 32'h00001234, 1);
    run_op("divovf", F_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 1);
    run_op("removf", F_REM,    32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h00000000, 1);

    // Signed divide
    run_op("div-7",  F_DIV,    32'hFFFFFFF9, 32'd2,        5'd18, 32'hFFFFFFFD, 33);
    run_op("rem-7",  F_REM,    32'hFFFFFFF9, 32'd2,        5'd19, 32'hFFFFFFFF, 33);

    // Backpressure: result held 5 cycles, then back-to-back accept
    issue(F_DIV, 32'hFFFFFFF9, 32'd2, 5'd9);
    wait_valid(lat);
    check("bp/latency", lat, 33);
    for (int i = 0; i < 5; i++) begin
      check("bp/out_valid", {31'd0, out_valid}, 32'd1);
      check("bp/out_val", out_val, 32'hFFFFFFFD);
      check("bp/out_rd", {27'd0, out_rd}, 32'd9);
      check("bp/in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    in_valid = 1'b1; in_funct = F_DIVU; in_a = 32'h55; in_b = 32'd0; in_rd = 5'd4;
    #1;
    check("b2b/in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b/out_valid", {31'd0, out_valid}, 32'd1);
    check("b2b/out_val", out_val, 32'hFFFFFFFF);
    check("b2b/out_rd", {27'd0, out_rd}, 32'd4);
    check("b2b/busy_rd", {27'd0, busy_rd}, 32'd4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("b2b/retired", {31'd0, out_valid}, 32'd0);

    // Flush on CALC cycle 10
    issue(F_MUL, 32'd7, 32'd3, 5'd7);
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    #1;
    check("flush/out_valid_now", {31'd0, out_valid}, 32'd0);
    tick();
    flush = 1'b0;
    check("flush/out_valid", {31'd0, out_valid}, 32'd0);
    check("flush/busy_rd", {27'd0, busy_rd}, 32'd0);
    check("flush/in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("flush/stale_valid", seen, 0);

    // Flush blocks an accept in IDLE
    in_valid = 1'b1; in_funct = F_DIVU; in_a = 32'd1; in_b = 32'd0; in_rd = 5'd8;
    flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle/out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_idle/busy_rd", {27'd0, busy_rd}, 32'd0);

    // Flush in DONE drops the result
    issue(F_DIVU, 32'd5, 32'd0, 5'd2);
    check("flush_done/valid_before", {31'd0, out_valid}, 32'd1);
    flush = 1'b1;
    #1;
    check("flush_done/gated", {31'd0, out_valid}, 32'd0);
    tick();
    flush = 1'b0;
    check("flush_done/out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_done/in_ready", {31'd0, in_ready}, 32'd1);

    // Asynchronous reset mid-CALC
    issue(F_MUL, 32'd9, 32'd9, 5'd5);
    for (int i = 0; i < 5; i++) tick();
    #2 reset = 1'b0;
    #1;
    check("arst/out_valid", {31'd0, out_valid}, 32'd0);
    check("arst/out_val", out_val, 32'd0);
    check("arst/out_rd", {27'd0, out_rd}, 32'd0);
    check("arst/busy_rd", {27'd0, busy_rd}, 32'd0);
    #1 reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("arst/stale_valid", seen, 0);
    run_op("mul_after_rst", F_MUL, 32'd3, 32'd5, 5'd6, 32'd15, 33);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
